// File: rtl/frame_pad.sv
// Vector-stream padder: wraps each input frame with a configurable number of
// leading/trailing pad vectors (zero or edge replica) behind one output register.
module frame_pad #(
  parameter int BW         = 8,
  parameter int VECTOR_LEN = 13,
  parameter int MAX_PAD    = 4,
  parameter int CW         = $clog2(MAX_PAD + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [CW-1:0]              pad_pre_i,
  input  logic [CW-1:0]              pad_post_i,
  input  logic                       mode_i,
  input  logic [VECTOR_LEN*BW-1:0]   data_i,
  input  logic                       valid_i,
  input  logic                       last_i,
  output logic                       ready_o,
  output logic [VECTOR_LEN*BW-1:0]   data_o,
  output logic                       valid_o,
  output logic                       last_o,
  input  logic                       ready_i
);

  localparam int DW = VECTOR_LEN * BW;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PAD);

  typedef enum logic [1:0] {IDLE, PRE, PASS, POST} state_t;

  state_t        state, state_n;
  logic [CW-1:0] remaining, remaining_n;
  logic [CW-1:0] post_cnt, post_cnt_n;
  logic          mode, mode_n;
  logic [DW-1:0] edge_vec, edge_vec_n;
  logic [DW-1:0] data_n;
  logic          valid_n, last_n;

  logic          adv;
  logic          start;
  logic          accept;
  logic [CW-1:0] pre_sat, post_sat, post_eff;
  logic [DW-1:0] pad_vec;

  assign adv      = !valid_o || ready_i;
  assign pre_sat  = (pad_pre_i  > MAX_CNT) ? MAX_CNT : pad_pre_i;
  assign post_sat = (pad_post_i > MAX_CNT) ? MAX_CNT : pad_post_i;
  // The frame's post count is still on the inputs when the first beat passes in IDLE.
  assign post_eff = (state == IDLE) ? post_sat : post_cnt;
  assign pad_vec  = mode ? edge_vec : '0;
  assign start    = (state == IDLE) && valid_i && adv;
  assign accept   = valid_i && ready_o;

  always_comb begin
    ready_o = 1'b0;
    if (!rst_i) begin
      case (state)
        IDLE:    ready_o = adv && (pre_sat == '0);
        PASS:    ready_o = adv;
        default: ready_o = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    post_cnt_n  = post_cnt;
    mode_n      = mode;
    edge_vec_n  = edge_vec;
    data_n      = data_o;
    valid_n     = valid_o;
    last_n      = last_o;
    if (adv) begin
      valid_n = 1'b0;
      last_n  = 1'b0;
    end
    case (state)
      IDLE, PASS: begin
        if (start) begin
          post_cnt_n = post_sat;
          mode_n     = mode_i;
        end
        if (start && (pre_sat != '0)) begin
          // Capture the first vector so later pre-pad beats can replicate it.
          valid_n     = 1'b1;
          data_n      = mode_i ? data_i : '0;
          edge_vec_n  = data_i;
          remaining_n = pre_sat - CW'(1);
          state_n     = (pre_sat == CW'(1)) ? PASS : PRE;
        end else if (accept) begin
          valid_n    = 1'b1;
          data_n     = data_i;
          edge_vec_n = data_i;
          if (last_i) begin
            if (post_eff != '0) begin
              remaining_n = post_eff;
              state_n     = POST;
            end else begin
              last_n  = 1'b1;
              state_n = IDLE;
            end
          end else begin
            state_n = PASS;
          end
        end
      end
      PRE: begin
        if (adv) begin
          valid_n     = 1'b1;
          data_n      = pad_vec;
          remaining_n = remaining - CW'(1);
          if (remaining == CW'(1)) state_n = PASS;
        end
      end
      POST: begin
        if (adv) begin
          valid_n     = 1'b1;
          data_n      = pad_vec;
          remaining_n = remaining - CW'(1);
          if (remaining == CW'(1)) begin
            last_n  = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      remaining <= '0;
      post_cnt  <= '0;
      mode      <= 1'b0;
      edge_vec  <= '0;
      data_o    <= '0;
      valid_o   <= 1'b0;
      last_o    <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      post_cnt  <= post_cnt_n;
      mode      <= mode_n;
      edge_vec  <= edge_vec_n;
      data_o    <= data_n;
      valid_o   <= valid_n;
      last_o    <= last_n;
    end
  end

endmodule

// File: tb/tb_frame_pad.sv
// Self-checking bench for frame_pad: directed scenarios plus randomized frames,
// all output beats scored against a frame-level padding model.
module tb_frame_pad;

  localparam int BW      = 8;
  localparam int VL      = 13;
  localparam int MAX_PAD = 4;
  localparam int CW      = $clog2(MAX_PAD + 1);
  localparam int DW      = BW * VL;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [CW-1:0] pad_pre_i, pad_post_i;
  logic          mode_i;
  logic [DW-1:0] data_i;
  logic          valid_i, last_i;
  logic          ready_o;
  logic [DW-1:0] data_o;
  logic          valid_o, last_o;
  logic          ready_i;

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    start_cyc = 0;
  int    ready_hi_cnt = 0;
  bit    rand_ready = 1'b0;
  bit    stall_prev = 1'b0;
  beat_t exp_q[$];
  logic [DW-1:0] frame_q[$];
  int    got_cyc_q[$];
  beat_t cur;

  frame_pad #(.BW(BW), .VECTOR_LEN(VL), .MAX_PAD(MAX_PAD)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pad_pre_i(pad_pre_i), .pad_post_i(pad_post_i),
    .mode_i(mode_i), .data_i(data_i), .valid_i(valid_i), .last_i(last_i),
    .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o), .last_o(last_o),
    .ready_i(ready_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Downstream ready: constant high for directed steps, random during the soak.
  always @(posedge clk_i) begin
    #1;
    ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_flag(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_count(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < VL; i++) v[i*BW +: BW] = BW'($urandom());
    return v;
  endfunction

  function automatic int first_cyc();
    return (got_cyc_q.size() > 0) ? got_cyc_q[0] : -1;
  endfunction

  function automatic int span_cyc();
    return (got_cyc_q.size() > 0) ? got_cyc_q[got_cyc_q.size()-1] - got_cyc_q[0] : -1;
  endfunction

  // Reference: padded frame = pre pads, the frame itself, post pads.
  task automatic model_frame(input int pre, input int post, input int mode);
    int np, nq, n;
    logic [DW-1:0] lead, trail;
    beat_t b;
    np = (pre  > MAX_PAD) ? MAX_PAD : pre;
    nq = (post > MAX_PAD) ? MAX_PAD : post;
    n  = frame_q.size();
    lead  = (mode != 0) ? frame_q[0]   : '0;
    trail = (mode != 0) ? frame_q[n-1] : '0;
    for (int i = 0; i < np; i++) begin
      b.data = lead; b.last = 1'b0; exp_q.push_back(b);
    end
    for (int i = 0; i < n; i++) begin
      b.data = frame_q[i]; b.last = (nq == 0) && (i == n - 1); exp_q.push_back(b);
    end
    for (int i = 0; i < nq; i++) begin
      b.data = trail; b.last = (i == nq - 1); exp_q.push_back(b);
    end
  endtask

  task automatic wait_accept();
    bit done;
    int n;
    done = 1'b0;
    n = 0;
    while (!done && n < 500) begin
      @(negedge clk_i);
      n++;
      if (ready_o) done = 1'b1;
      @(posedge clk_i);
      #1;
    end
    check_flag("accept", done, 1'b1);
  endtask

  task automatic applyStimulus(input int pre, input int post, input int mode);
    model_frame(pre, post, mode);
    pad_pre_i  = CW'(pre);
    pad_post_i = CW'(post);
    mode_i     = (mode != 0);
    start_cyc  = cyc;
    for (int i = 0; i < frame_q.size(); i++) begin
      data_i  = frame_q[i];
      last_i  = (i == frame_q.size() - 1);
      valid_i = 1'b1;
      wait_accept();
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk_i);
      n++;
    end
    check_flag(tag, exp_q.size() == 0, 1'b1);
    @(posedge clk_i);
    #1;
  endtask

  task automatic new_frame(input int len);
    frame_q.delete();
    for (int i = 0; i < len; i++) frame_q.push_back(rand_vec());
  endtask

  // Single-vector frame, pre=3 post=3 replicate; reset after n cycles.
  task automatic reset_mid_frame(input string tag, input int n);
    bit acc;
    new_frame(1);
    model_frame(3, 3, 1);
    pad_pre_i = 3; pad_post_i = 3; mode_i = 1'b1;
    data_i = frame_q[0]; last_i = 1'b1; valid_i = 1'b1;
    for (int c = 0; c < n; c++) begin
      @(negedge clk_i);
      acc = valid_i && ready_o;
      @(posedge clk_i);
      #1;
      if (acc) begin valid_i = 1'b0; last_i = 1'b0; end
    end
    rst_i = 1'b1;
    #1;
    check_flag({tag, "_ready_in_rst"}, ready_o, 1'b0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0; valid_i = 1'b0; last_i = 1'b0;
    exp_q.delete();
    check_flag({tag, "_valid_after_rst"}, valid_o, 1'b0);
    check_flag({tag, "_last_after_rst"}, last_o, 1'b0);
    checkOutput({tag, "_data_after_rst"}, data_o, '0);
    new_frame(2);
    got_cyc_q.delete();
    applyStimulus(2, 1, 1);
    wait_drain({tag, "_recover_drain"});
    check_count({tag, "_recover_beats"}, got_cyc_q.size(), 5);
  endtask

  // Scoreboard: every valid output cycle must show the model's head beat.
  always @(negedge clk_i) begin
    if (rst_i) begin
      stall_prev = 1'b0;
    end else begin
      if (ready_o) ready_hi_cnt++;
      if (stall_prev) check_flag("stall_hold_valid", valid_o, 1'b1);
      if (valid_o) begin
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("[TB] FAIL unexpected_beat observed=%h expected=no_beat", data_o);
        end
        if (exp_q.size() != 0) begin
          checkOutput("beat_data", data_o, exp_q[0].data);
          check_flag("beat_last", last_o, exp_q[0].last);
          if (ready_i) begin
            cur = exp_q.pop_front();
            got_cyc_q.push_back(cyc);
          end
        end
      end
      stall_prev = valid_o && !ready_i;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; last_i = 1'b0; data_i = '0;
    pad_pre_i = 1; pad_post_i = 1; mode_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_flag("rst_ready", ready_o, 1'b0);
    check_flag("rst_valid", valid_o, 1'b0);
    check_flag("rst_last", last_o, 1'b0);
    checkOutput("rst_data", data_o, '0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    $display("[TB] default zero padding");
    new_frame(3); got_cyc_q.delete();
    applyStimulus(1, 1, 0);
    wait_drain("t1_drain");
    check_count("t1_beats", got_cyc_q.size(), 5);
    check_count("t1_latency", first_cyc(), start_cyc + 1);
    check_count("t1_span", span_cyc(), 4);

    $display("[TB] replicate pre=2 post=3");
    new_frame(2); got_cyc_q.delete(); ready_hi_cnt = 0;
    applyStimulus(2, 3, 1);
    wait_drain("t2_drain");
    check_count("t2_beats", got_cyc_q.size(), 7);
    check_count("t2_ready_cycles", ready_hi_cnt, 2);
    check_count("t2_span", span_cyc(), 6);

    $display("[TB] no padding");
    new_frame(3); got_cyc_q.delete();
    applyStimulus(0, 0, 0);
    wait_drain("t3_drain");
    check_count("t3_beats", got_cyc_q.size(), 3);
    check_count("t3_latency", first_cyc(), start_cyc + 1);
    check_count("t3_span", span_cyc(), 2);

    $display("[TB] saturated pad counts");
    new_frame(1); got_cyc_q.delete();
    applyStimulus(7, 5, 0);
    wait_drain("t4_drain");
    check_count("t4_beats", got_cyc_q.size(), 9);
    check_count("t4_latency", first_cyc(), start_cyc + 1);
    check_count("t4_span", span_cyc(), 8);

    $display("[TB] back-to-back frames");
    got_cyc_q.delete();
    new_frame(2);
    applyStimulus(1, 1, 1);
    new_frame(1);
    applyStimulus(0, 2, 0);
    wait_drain("t5_drain");
    check_count("t5_beats", got_cyc_q.size(), 7);
    check_count("t5_span", span_cyc(), 6);

    $display("[TB] random backpressure and config");
    rand_ready = 1'b1;
    for (int f = 0; f < 16; f++) begin
      new_frame($urandom_range(1, 5));
      applyStimulus($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk_i);
        #1;
      end
    end
    wait_drain("rand_drain");
    rand_ready = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;

    $display("[TB] reset in each phase");
    reset_mid_frame("rst_pre", 1);
    reset_mid_frame("rst_pass", 3);
    reset_mid_frame("rst_post", 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_pad.md
# frame_pad

Parametrised vector-stream padder for the wake-word datapath: it inserts a runtime-selectable number of leading and trailing pad vectors around each frame before the conv stages. Pad vectors are either zero or a replica of the frame's first or last vector. It supports full valid/ready backpressure with one registered output stage and zero dead cycles between frames. With default configuration it generalises single zero padding on each side.

## Interface
- BW, 8, bits per vector element
- VECTOR_LEN, 13, elements per vector
- MAX_PAD, 4, maximum pad vectors per side; must be at least 1
- CW, $clog2(MAX_PAD+1), width of pad-count inputs (derived)
- clk_i  in  1  clock; all logic on posedge
- rst_i  in  1  reset, synchronous, active-high
- pad_pre_i  in  CW  leading pad count; sampled at frame start
- pad_post_i  in  CW  trailing pad count; sampled at frame start
- mode_i  in  1  0 = zero pad, 1 = replicate edge vector; sampled at frame start
- data_i  in  VECTOR_LEN*BW  input vector, signed elements
- valid_i  in  1  input valid
- last_i  in  1  marks final vector of input frame
- ready_o  out  1  input accepted when valid_i & ready_o
- data_o  out  VECTOR_LEN*BW  output vector (registered)
- valid_o  out  1  output valid (registered)
- last_o  out  1  marks final beat of padded frame, including trailing pad (registered)
- ready_i  in  1  downstream ready

## Operation
- Output register (data_o/valid_o/last_o) loads when adv = !valid_o | ready_i. When valid_o & !ready_i, all three outputs hold.
- Config is latched when a frame starts. pre and post saturate to MAX_PAD: a value of 7 with MAX_PAD = 4 yields 4.
- Pad value: zero when mode = 0. When mode = 1, pre-pad is the first vector taken from data_i, which is held stable by the valid/ready rule. Post-pad is the last accepted vector, stored in an internal edge register.
- FSM states: IDLE, PRE, PASS, POST.
  - IDLE: waits for valid_i.
    - If pre > 0 and adv: load pad beat, set remaining = pre-1, go to PRE (or PASS if pre = 1). ready_o = 0.
    - If pre = 0: ready_o = adv and the beat passes through as in PASS.
  - PRE: ready_o = 0. Each adv loads one pad beat. Go to PASS when remaining reaches 0.
  - PASS: ready_o = adv. An accepted beat loads data_i into the output register and into the edge register.
    - On an accepted last_i with post > 0: last_o = 0, go to POST with remaining = post.
    - On an accepted last_i with post = 0: last_o = 1, go to IDLE.
  - POST: ready_o = 0. Each adv loads one pad beat; the final one carries last_o = 1. Then go to IDLE.
- A single-vector frame is legal (valid_i & last_i on the first beat).
- Input frames are at least one vector long. last_i is only observed on accepted beats.

## Timing
- Reset (rst_i high at posedge): state = IDLE; valid_o = 0, last_o = 0, data_o = 0; edge register = 0.
  - ready_o is forced to 0 while rst_i = 1.
  - Reset mid-frame discards the in-flight frame. No partial last_o is emitted.
- Latency: first output beat valid the cycle after valid_i is seen in IDLE (1 cycle).
- Throughput: 1 beat/cycle when ready_i = 1. The output frame length is pre + N + post beats.
- Back-to-back frames: the next frame's first beat can load the cycle after the last_o beat loads, with zero idle beats on the output.
- ready_o is combinational from state, config inputs and adv. There is no combinational path from data_i to data_o.

## Test plan
- Defaults pre = 1, post = 1, mode 0; frame A,B,C with ready_i = 1 -> data_o sequence 0,A,B,C,0 on 5 consecutive cycles; last_o only on the 5th beat; first beat 1 cycle after valid_i.
- mode 1, pre = 2, post = 3; frame A,B -> A,A,A,B,B,B,B; last_o on the 7th beat; ready_o high exactly 2 cycles.
- pre = 0, post = 0; frame A,B,C -> A,B,C with 1-cycle latency and ready_o = ready_i; last_o on C.
- MAX_PAD = 4, pad_pre_i = 7, pad_post_i = 5, mode 0, frame A -> 4 zeros, A, 4 zeros (9 beats).
- Random ready_i toggling plus back-to-back frames with changing config -> data_o/last_o stable while stalled, no lost or duplicated beats, no bubble between frames when ready_i = 1; scoreboard against a reference model.
- rst_i asserted during the PRE, PASS and POST phases -> valid_o = 0 next cycle; the following frame is padded correctly from IDLE.
